// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one port of the dual_port_ram between two requesters:
//   requester 0 : Processador data path (CPU)
//   requester 1 : SPI load/debug engine
// Round-robin arbitration with optional burst locking; a locked owner keeps
// the port for at most MAX_BURST consecutive grants while the other side is
// waiting. Read data returns with the RAM's 1-cycle synchronous latency.
//
// Ports:
//   clock_i, reset_i               clock, synchronous active-high reset
//   reqN_i, lockN_i, weN_i         request, burst lock, write enable
//   addrN_i, wdataN_i              access address / write data
//   gntN_o                         access accepted this cycle (combinational)
//   rvalidN_o, rdataN_o            read return (rdata is 0 when not valid)
//   mem_en_o, mem_we_o,
//   mem_addr_o, mem_wdata_o        RAM port controls
//   mem_rdata_i                    RAM read data, 1 cycle after read enable
//
// Optional macro ARB_STATS_EN adds saturating 16-bit counters:
//   stat_gnt0_o, stat_gnt1_o       grants per requester
//   stat_conflict_o                cycles with both requests high
//
// state | meaning
// IDLE  | no owner, round-robin between requesters
// OWN0  | requester 0 holds a locked burst
// OWN1  | requester 1 holds a locked burst
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  req0_i,
    input  logic                  req1_i,
    input  logic                  lock0_i,
    input  logic                  lock1_i,
    input  logic                  we0_i,
    input  logic                  we1_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    output logic                  gnt0_o,
    output logic                  gnt1_o,
    output logic                  rvalid0_o,
    output logic                  rvalid1_o,
    output logic [DATA_WIDTH-1:0] rdata0_o,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef ARB_STATS_EN
   ,output logic [15:0]           stat_gnt0_o,
    output logic [15:0]           stat_gnt1_o,
    output logic [15:0]           stat_conflict_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Grant number (0-based) at which a contended burst must end.
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic [1:0] rd_pend_q, rd_pend_d;

    logic       gnt0, gnt1;
    logic       sel_lock, sel_other, sel_owned, limit_hit;
    logic [7:0] eff_cnt;

    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        state_d     = IDLE;
        last_d      = last_q;
        burst_cnt_d = 8'd0;
        rd_pend_d   = 2'b00;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        sel_lock    = 1'b0;
        sel_other   = 1'b0;
        sel_owned   = 1'b0;
        eff_cnt     = 8'd0;
        limit_hit   = 1'b0;

        if (!reset_i) begin
            // A locked owner that stops requesting falls back to plain
            // round-robin in the same cycle.
            if (state_q == OWN0 && req0_i) begin
                gnt0 = 1'b1;
            end else if (state_q == OWN1 && req1_i) begin
                gnt1 = 1'b1;
            end else if (req0_i && req1_i) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = req0_i;
                gnt1 = req1_i;
            end

            if (gnt0) begin
                sel_lock     = lock0_i;
                sel_other    = req1_i;
                sel_owned    = (state_q == OWN0);
                mem_en_o     = 1'b1;
                mem_we_o     = we0_i;
                mem_addr_o   = addr0_i;
                mem_wdata_o  = wdata0_i;
                last_d       = 1'b0;
                rd_pend_d[0] = !we0_i;
            end else if (gnt1) begin
                sel_lock     = lock1_i;
                sel_other    = req0_i;
                sel_owned    = (state_q == OWN1);
                mem_en_o     = 1'b1;
                mem_we_o     = we1_i;
                mem_addr_o   = addr1_i;
                mem_wdata_o  = wdata1_i;
                last_d       = 1'b1;
                rd_pend_d[1] = !we1_i;
            end

            // burst_cnt holds the number of contended grants already given
            // in the current burst; a fresh burst starts counting at zero.
            eff_cnt   = sel_owned ? burst_cnt_q : 8'd0;
            limit_hit = sel_other && (eff_cnt >= BURST_LAST);

            if ((gnt0 || gnt1) && sel_lock && !limit_hit) begin
                state_d     = gnt0 ? OWN0 : OWN1;
                burst_cnt_d = sel_other ? 8'(eff_cnt + 8'd1) : 8'd0;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            burst_cnt_q <= 8'd0;
            rd_pend_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    assign gnt0_o = gnt0;
    assign gnt1_o = gnt1;

    // Gating with reset keeps a read issued just before reset from
    // surfacing during the reset cycle.
    assign rvalid0_o = rd_pend_q[0] && !reset_i;
    assign rvalid1_o = rd_pend_q[1] && !reset_i;
    assign rdata0_o  = rvalid0_o ? mem_rdata_i : '0;
    assign rdata1_o  = rvalid1_o ? mem_rdata_i : '0;

`ifdef ARB_STATS_EN
    logic [15:0] stat_gnt0_q, stat_gnt1_q, stat_conflict_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stat_gnt0_q     <= 16'd0;
            stat_gnt1_q     <= 16'd0;
            stat_conflict_q <= 16'd0;
        end else begin
            if (gnt0 && stat_gnt0_q != 16'hFFFF) begin
                stat_gnt0_q <= stat_gnt0_q + 16'd1;
            end
            if (gnt1 && stat_gnt1_q != 16'hFFFF) begin
                stat_gnt1_q <= stat_gnt1_q + 16'd1;
            end
            if (req0_i && req1_i && stat_conflict_q != 16'hFFFF) begin
                stat_conflict_q <= stat_conflict_q + 16'd1;
            end
        end
    end

    assign stat_gnt0_o     = stat_gnt0_q;
    assign stat_gnt1_o     = stat_gnt1_q;
    assign stat_conflict_o = stat_conflict_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Table of per-cycle {inputs, expected grants/rvalids}, followed by
// hand-written sequences for burst limiting, uncontended lock, reset during a
// read return and (with ARB_STATS_EN) the statistics counters. A RAM model
// drives mem_rdata; a shadow memory plus a queue of expected read returns
// checks every rvalid/rdata the arbiter produces.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clock, reset;
    logic        req0, req1, lock0, lock1, we0, we1;
    logic [7:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
`ifdef ARB_STATS_EN
    logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clock_i    (clock),
        .reset_i    (reset),
        .req0_i     (req0),
        .req1_i     (req1),
        .lock0_i    (lock0),
        .lock1_i    (lock1),
        .we0_i      (we0),
        .we1_i      (we1),
        .addr0_i    (addr0),
        .addr1_i    (addr1),
        .wdata0_i   (wdata0),
        .wdata1_i   (wdata1),
        .gnt0_o     (gnt0),
        .gnt1_o     (gnt1),
        .rvalid0_o  (rvalid0),
        .rvalid1_o  (rvalid1),
        .rdata0_o   (rdata0),
        .rdata1_o   (rdata1),
        .mem_en_o   (mem_en),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
`ifdef ARB_STATS_EN
       ,.stat_gnt0_o    (stat_gnt0),
        .stat_gnt1_o    (stat_gnt1),
        .stat_conflict_o(stat_conflict)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM port model: synchronous read, 1-cycle latency.
    logic [31:0] ram [256];
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: expected read returns pushed at grant, popped next cycle.
    typedef struct {
        logic        id;
        logic [31:0] data;
    } rd_t;
    rd_t         exp_q[$];
    logic [31:0] shadow [256];

    always @(negedge clock) begin
        rd_t e;
        if (reset) begin
            chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
            exp_q.delete();
        end else begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_rvalid", 32'({rvalid1, rvalid0}), e.id ? 32'd2 : 32'd1);
                chk("sb_rdata", e.id ? rdata1 : rdata0, e.data);
            end else begin
                chk("sb_no_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
                chk("sb_rdata_zero", rdata0 | rdata1, 32'd0);
            end
            chk("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
            if (gnt0) begin
                if (we0) shadow[addr0] = wdata0;
                else begin e.id = 1'b0; e.data = shadow[addr0]; exp_q.push_back(e); end
            end
            if (gnt1) begin
                if (we1) shadow[addr1] = wdata1;
                else begin e.id = 1'b1; e.data = shadow[addr1]; exp_q.push_back(e); end
            end
        end
    end

    typedef struct {
        logic        rst, r0, r1, l0, l1, w0, w1;
        logic [7:0]  a0, a1;
        logic [31:0] d0, d1;
        logic        g0, g1, rv0, rv1;
    } vec_t;

    function automatic vec_t mk(logic rst, logic r0, logic r1, logic l0, logic l1,
                                logic w0, logic w1, logic [7:0] a0, logic [7:0] a1,
                                logic [31:0] d0, logic [31:0] d1,
                                logic g0, logic g1, logic rv0, logic rv1);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1; v.w0 = w0; v.w1 = w1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rv1 = rv1;
        return v;
    endfunction

    task automatic clear_in();
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        we0 = 1'b0; we1 = 1'b0; addr0 = 8'h00; addr1 = 8'h00;
        wdata0 = 32'h0; wdata1 = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    vec_t vecs[19];
    int   n1, c, zero_grants;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(1, 0,0,0,0,0,0, 8'h00,8'h00, 32'h0,32'h0,              0,0,0,0);
        vecs[1]  = mk(1, 1,1,0,0,0,0, 8'h05,8'h06, 32'h0,32'h0,              0,0,0,0);
        vecs[2]  = mk(0, 1,0,0,0,1,0, 8'h05,8'h00, 32'h00009312,32'h0,       1,0,0,0);
        vecs[3]  = mk(0, 1,0,0,0,0,0, 8'h05,8'h00, 32'h0,32'h0,              1,0,0,0);
        vecs[4]  = mk(0, 0,0,0,0,0,0, 8'h00,8'h00, 32'h0,32'h0,              0,0,1,0);
        vecs[5]  = mk(1, 0,0,0,0,0,0, 8'h00,8'h00, 32'h0,32'h0,              0,0,0,0);
        vecs[6]  = mk(0, 1,1,0,0,1,1, 8'h10,8'h20, 32'hA0,32'hB1,            1,0,0,0);
        vecs[7]  = mk(0, 1,1,0,0,1,1, 8'h11,8'h20, 32'hA2,32'hB1,            0,1,0,0);
        vecs[8]  = mk(0, 1,1,0,0,1,1, 8'h11,8'h21, 32'hA2,32'hB3,            1,0,0,0);
        vecs[9]  = mk(0, 1,1,0,0,1,1, 8'h12,8'h21, 32'hA4,32'hB3,            0,1,0,0);
        vecs[10] = mk(0, 1,1,0,0,1,0, 8'h12,8'h20, 32'hA4,32'h0,             1,0,0,0);
        vecs[11] = mk(0, 1,1,0,0,0,0, 8'h10,8'h20, 32'h0,32'h0,              0,1,0,0);
        vecs[12] = mk(0, 1,1,0,0,0,0, 8'h10,8'h21, 32'h0,32'h0,              1,0,0,1);
        vecs[13] = mk(0, 0,1,1,0,0,0, 8'h00,8'h21, 32'h0,32'h0,              0,1,1,0);
        vecs[14] = mk(0, 0,0,0,0,0,0, 8'h00,8'h00, 32'h0,32'h0,              0,0,0,1);
        vecs[15] = mk(0, 1,1,1,0,0,0, 8'h11,8'h12, 32'h0,32'h0,              1,0,0,0);
        vecs[16] = mk(0, 1,1,0,0,0,0, 8'h12,8'h12, 32'h0,32'h0,              1,0,1,0);
        vecs[17] = mk(0, 0,1,0,0,0,0, 8'h00,8'h12, 32'h0,32'h0,              0,1,1,0);
        vecs[18] = mk(0, 0,0,0,0,0,0, 8'h00,8'h00, 32'h0,32'h0,              0,0,0,1);

        clear_in();
        reset = 1'b1;
        next_cycle();

        for (int i = 0; i < 19; i++) begin
            reset = vecs[i].rst; req0 = vecs[i].r0; req1 = vecs[i].r1;
            lock0 = vecs[i].l0; lock1 = vecs[i].l1; we0 = vecs[i].w0; we1 = vecs[i].w1;
            addr0 = vecs[i].a0; addr1 = vecs[i].a1; wdata0 = vecs[i].d0; wdata1 = vecs[i].d1;
            @(negedge clock);
            chk($sformatf("v%0d_gnt", i), 32'({gnt1, gnt0}), 32'({vecs[i].g1, vecs[i].g0}));
            chk($sformatf("v%0d_rvalid", i), 32'({rvalid1, rvalid0}),
                32'({vecs[i].rv1, vecs[i].rv0}));
            chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].g0 | vecs[i].g1));
            if (vecs[i].g0) begin
                chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].a0));
                chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].w0));
            end else if (vecs[i].g1) begin
                chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].a1));
                chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].w1));
            end
            if (i == 4) chk("cpu_rdata_9312", rdata0, 32'h00009312);
            next_cycle();
        end

        // Burst limit: locked requester 1 versus waiting requester 0.
        clear_in();
        reset = 1'b1;
        next_cycle();
        clear_in();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h01; wdata0 = 32'h11;
        @(negedge clock);
        chk("burst_pre_gnt0", 32'(gnt0), 32'd1);
        next_cycle();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'hAA; wdata0 = 32'hCAFE;
        n1 = 0; c = 0; zero_grants = 0;
        while (n1 < 20 && c < 40) begin
            req1 = 1'b1; lock1 = 1'b1; we1 = 1'b1;
            addr1 = 8'h40 + 8'(n1); wdata1 = 32'h100 + 32'(n1);
            @(negedge clock);
            chk($sformatf("burst_c%0d_gnt", c), 32'({gnt1, gnt0}), (c == 8) ? 32'd1 : 32'd2);
            if (gnt1) n1++;
            if (gnt0) begin
                zero_grants++;
                chk("burst_addr0", 32'(mem_addr), 32'h000000AA);
            end
            next_cycle();
            if (zero_grants != 0) req0 = 1'b0;
            c++;
        end
        chk("burst_gnt0_once", 32'(zero_grants), 32'd1);
        chk("burst_cycles", 32'(c), 32'd21);
        clear_in();
        next_cycle();

        // Lock without contention: no burst counting.
        for (int i = 0; i < 20; i++) begin
            req0 = 1'b1; lock0 = 1'b1; we0 = 1'b1;
            addr0 = 8'h80 + 8'(i); wdata0 = 32'h200 + 32'(i);
            @(negedge clock);
            chk($sformatf("nolock_c%0d_gnt0", i), 32'({gnt1, gnt0}), 32'd1);
            chk($sformatf("nolock_c%0d_cnt", i), 32'(dut.burst_cnt_q), 32'd0);
            next_cycle();
        end
        clear_in();
        next_cycle();

        // Reset the cycle after a requester-1 read.
        req1 = 1'b1; addr1 = 8'h20;
        @(negedge clock);
        chk("rstrd_gnt1", 32'({gnt1, gnt0}), 32'd2);
        next_cycle();
        clear_in();
        reset = 1'b1;
        @(negedge clock);
        chk("rstrd_rvalid1", 32'(rvalid1), 32'd0);
        next_cycle();
        clear_in();
        req0 = 1'b1; addr0 = 8'h10; req1 = 1'b1; addr1 = 8'h20;
        @(negedge clock);
        chk("rstrd_state_idle", 32'(dut.state_q), 32'd0);
        chk("rstrd_rvalid1_after", 32'(rvalid1), 32'd0);
        chk("rstrd_tie_gnt0", 32'({gnt1, gnt0}), 32'd1);
        next_cycle();
        req0 = 1'b0;
        @(negedge clock);
        chk("rstrd_then_gnt1", 32'({gnt1, gnt0}), 32'd2);
        next_cycle();
        clear_in();
        next_cycle();

`ifdef ARB_STATS_EN
        reset = 1'b1;
        next_cycle();
        clear_in();
        for (int i = 0; i < 13; i++) begin
            req0 = 1'b1; we0 = 1'b1; addr0 = 8'hC0; wdata0 = 32'h300 + 32'(i);
            req1 = (i < 10); we1 = 1'b1; addr1 = 8'hD0; wdata1 = 32'h400 + 32'(i);
            next_cycle();
        end
        clear_in();
        @(negedge clock);
        chk("stat_conflict", 32'(stat_conflict), 32'd10);
        chk("stat_gnt0", 32'(stat_gnt0), 32'd8);
        chk("stat_gnt1", 32'(stat_gnt1), 32'd5);
        next_cycle();
`endif

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter that shares one port of the 8-bit-address / 32-bit-data dual_port_ram between the Processador data path (requester 0) and the SPI load/debug engine (requester 1).
- Sits between the requesters and the RAM port interface signals (en, we, addr, wdata, rdata).
- Arbitration is round-robin with optional burst locking and a bounded burst length.
- Read data is returned with the RAM's 1-cycle synchronous latency.

Parameters:
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 32, RAM data width.
- MAX_BURST, 8, maximum consecutive grants to one locked owner while the other requester is waiting (1..255).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request, requester 0 (CPU) / requester 1 (SPI).
- lock0 / lock1  in  1  keep ownership after this access (burst).
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_WIDTH  access address.
- wdata0 / wdata1  in  DATA_WIDTH  write data.
- gnt0 / gnt1  out  1  access accepted this cycle (combinational from state and req).
- rvalid0 / rvalid1  out  1  read data valid for that requester.
- rdata0 / rdata1  out  DATA_WIDTH  read data; equals mem_rdata when rvalid is high, 0 otherwise.
- mem_en  out  1  RAM port enable.
- mem_we  out  1  RAM port write enable.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after a read enable.

Behaviour:
- FSM states: IDLE, OWN0, OWN1. Registers: state, last (last granted id), burst_cnt (8 bit), rd_pend[1:0].
- Reset values:
  - state=IDLE, last=1 (so requester 0 wins the first tie), burst_cnt=0, rd_pend=0.
  - gnt*, rvalid*, mem_en, mem_we = 0; mem_addr, mem_wdata, rdata* = 0.
- IDLE:
  - Only one req high: grant it.
  - Both high: grant !last.
  - Neither high: outputs idle, mem_en=0.
- OWNx:
  - Owner x is granted if reqx=1.
  - If reqx=0, behave as IDLE this cycle (the other requester may be granted in the same cycle).
- On any grant to x:
  - Drive mem_en=1 with wex, addrx, wdatax to the RAM the same cycle.
  - Set last=x.
- Next state after a grant to x:
  - OWNx if lockx=1 and burst limit not reached.
  - Otherwise IDLE.
- burst_cnt:
  - Increments on each grant while in OWNx and the other requester is requesting.
  - Resets to 0 on leaving OWNx or when the other requester is idle.
  - When burst_cnt reaches MAX_BURST-1 and the other requester is waiting, the next state is forced to IDLE, ignoring lock; round-robin then grants the other requester.
- Non-granted requester:
  - gnt=0; it must hold req/addr/we/wdata stable until granted.
  - The arbiter never drops a pending request.
- Read return:
  - A granted read sets rd_pend[x].
  - Next cycle: rvalidx=1, rdatax=mem_rdata.
  - Back-to-back reads from different requesters return in grant order, one per cycle.
- Writes produce no rvalid.
- At most one grant per cycle; gnt0 & gnt1 is never 1.
- Reset mid-operation: a pending rvalid is suppressed (rvalid stays 0 the cycle after reset), lock is cleared, state returns to IDLE.
- Lock asserted with req low has no effect.
- MAX_BURST=1: lock is effectively ignored whenever the other requester is waiting.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds outputs stat_gnt0, stat_gnt1 (16 bit each, grants per requester) and stat_conflict (16 bit, cycles with req0 & req1 both high).
  - All three saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters do not exist; no other behaviour change.

Test Plan:
- Single CPU write then read, addr 8'h05, data 32'h00009312:
  - gnt0 in the request cycle, mem_we=1.
  - The read one cycle later gives rvalid0=1 with rdata0=32'h00009312 in the following cycle.
- Simultaneous req0=req1=1 (no lock) for 4 cycles after reset: grants alternate 0,1,0,1; gnt0 & gnt1 never both 1.
- lock1=1 burst of 20 writes with req0 held high, MAX_BURST=8:
  - 8 consecutive gnt1, then one gnt0, then gnt1 resumes.
  - addr0 stays stable and is granted exactly once.
- Lock with no contention: lock0=1, req1=0 for 20 accesses → gnt0 every cycle, burst_cnt stays 0.
- Reset asserted the cycle after a granted read from requester 1: rvalid1 stays 0, state=IDLE, next tie grants requester 0.
- With ARB_STATS_EN: 10 contended cycles then 3 CPU-only cycles → stat_conflict=10, stat_gnt0=8, stat_gnt1=5.
